// File: rtl/debug_trace_checker.sv
// Trace checker: buffers CPU register-file writebacks and compares them in order
// against a golden stream, flagging the first mismatch, overflow or commit timeout.
module debug_trace_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    input  logic        gold_last,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [4:0]  err_wnum,
    output logic [31:0] err_wdata,
    output logic [31:0] pass_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_ERROR} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    state_t        state, state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tmo_cnt;

    logic in_run, commit, fifo_empty, fifo_full;
    logic hs, data_ok, match, mismatch, overflow, timeout_hit, push, pop;

    assign in_run     = (state == ST_RUN);
    assign commit     = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign head       = mem[rd_ptr];

    assign gold_ready = in_run && !fifo_empty;
    assign hs         = gold_valid && gold_ready;
    assign pop        = hs;

    // Bytes not written by the CPU are don't-care in the data comparison.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (head.wen[i] && (head.wdata[8*i +: 8] != gold_wdata[8*i +: 8]))
                data_ok = 1'b0;
        end
    end

    assign match       = (head.pc == gold_pc) && (head.wnum == gold_wnum) && data_ok;
    assign mismatch    = hs && !match;
    assign overflow    = in_run && commit && fifo_full && !pop;
    assign push        = in_run && commit && (!fifo_full || pop);
    assign timeout_hit = in_run && !commit && (tmo_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    // Next-state logic: any error wins over completion
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (mismatch || overflow || timeout_hit) state_nxt = ST_ERROR;
                else if (hs && gold_last)                state_nxt = ST_DONE;
            end
            default: state_nxt = state;
        endcase
    end

    // Output logic
    always_comb begin
        done = (state == ST_DONE);
        err  = (state == ST_ERROR);
    end

    // NOTE: the entry storage has no reset; occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     tmo_cnt <= '0;
        else if (in_run) tmo_cnt <= commit ? '0 : tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_cnt  <= '0;
            err_code  <= 2'd0;
            err_pc    <= '0;
            err_wnum  <= '0;
            err_wdata <= '0;
        end else begin
            if (hs && match) pass_cnt <= pass_cnt + 32'd1;
            if (mismatch) begin
                err_code  <= 2'd1;
                err_pc    <= head.pc;
                err_wnum  <= head.wnum;
                err_wdata <= head.wdata;
            end else if (overflow) begin
                err_code  <= 2'd2;
            end else if (timeout_hit) begin
                err_code  <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_debug_trace_checker.sv
// Directed bench for debug_trace_checker: a per-cycle vector table plus
// hand-written overflow, timeout and mid-run reset sequences.
module tb_debug_trace_checker;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] debug_wb_pc = '0;
    logic [3:0]  debug_wb_rf_wen = '0;
    logic [4:0]  debug_wb_rf_wnum = '0;
    logic [31:0] debug_wb_rf_wdata = '0;
    logic        gold_valid = 1'b0;
    logic        gold_ready;
    logic [31:0] gold_pc = '0;
    logic [4:0]  gold_wnum = '0;
    logic [31:0] gold_wdata = '0;
    logic        gold_last = 1'b0;
    logic        done, err;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_wdata, pass_cnt;
    logic [4:0]  err_wnum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_trace_checker #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .gold_last(gold_last),
        .done(done), .err(err), .err_code(err_code), .err_pc(err_pc),
        .err_wnum(err_wnum), .err_wdata(err_wdata), .pass_cnt(pass_cnt)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        gv;
        logic [31:0] gpc;
        logic [4:0]  gwnum;
        logic [31:0] gwdata;
        logic        glast;
        logic        exp_ready;
        logic [31:0] exp_pass;
        logic        exp_done;
        logic [1:0]  exp_code;
        logic [31:0] exp_err_pc;
        logic [4:0]  exp_err_wnum;
        logic [31:0] exp_err_wdata;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [3:0] wen,
                              input logic [4:0] wnum, input logic [31:0] wdata);
        debug_wb_pc       = pc;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wdata;
    endtask

    task automatic set_gold(input logic v, input logic [31:0] pc, input logic [4:0] wnum,
                            input logic [31:0] wdata, input logic last);
        gold_valid = v;
        gold_pc    = pc;
        gold_wnum  = wnum;
        gold_wdata = wdata;
        gold_last  = last;
    endtask

    task automatic idle();
        set_commit(32'h0, 4'h0, 5'd0, 32'h0);
        set_gold(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
    endtask

    // Ends on a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        idle();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] e_pc(input int i);
        return 32'h0000_1000 + 32'(4 * i);
    endfunction
    function automatic logic [4:0] e_wnum(input int i);
        return 5'(i + 1);
    endfunction
    function automatic logic [31:0] e_wdata(input int i);
        return 32'h0101_0101 * 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // rst, pc, wen, wnum, wdata, gv, gpc, gwnum, gwdata, glast, ready, pass, done, code, epc, ewnum, ewdata
        vecs[0]  = '{1'b1, 32'hBFC00000, 4'hF, 5'd1, 32'h11111111, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0,
                     1'b0, 32'd0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[1]  = '{1'b0, 32'hBFC00004, 4'hF, 5'd2, 32'h22222222, 1'b1, 32'hBFC00000, 5'd1, 32'h11111111, 1'b0,
                     1'b1, 32'd1, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[2]  = '{1'b0, 32'hBFC00008, 4'hF, 5'd3, 32'h33333333, 1'b1, 32'hBFC00004, 5'd2, 32'h22222222, 1'b0,
                     1'b1, 32'd2, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 32'hBFC00008, 5'd3, 32'h33333333, 1'b1,
                     1'b1, 32'd3, 1'b1, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[4]  = '{1'b0, 32'hBFC0000C, 4'hF, 5'd4, 32'h44444444, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0,
                     1'b0, 32'd3, 1'b1, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[5]  = '{1'b1, 32'hBFC00100, 4'h3, 5'd4, 32'hAAAA1234, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0,
                     1'b0, 32'd0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 32'hBFC00100, 5'd4, 32'h55551234, 1'b0,
                     1'b1, 32'd1, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[7]  = '{1'b0, 32'hBFC00104, 4'h3, 5'd4, 32'hAAAA1234, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0,
                     1'b0, 32'd1, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 32'hBFC00104, 5'd4, 32'h55551235, 1'b0,
                     1'b1, 32'd1, 1'b0, 2'd1, 32'hBFC00104, 5'd4, 32'hAAAA1234};
        vecs[9]  = '{1'b0, 32'hBFC00108, 4'hF, 5'd6, 32'h66666666, 1'b1, 32'hBFC00108, 5'd6, 32'h66666666, 1'b1,
                     1'b0, 32'd1, 1'b0, 2'd1, 32'hBFC00104, 5'd4, 32'hAAAA1234};
        vecs[10] = '{1'b1, 32'hBFC00200, 4'hF, 5'd0, 32'h77777777, 1'b1, 32'hBFC00200, 5'd0, 32'h77777777, 1'b0,
                     1'b0, 32'd0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[11] = '{1'b0, 32'hBFC00204, 4'h0, 5'd5, 32'h88888888, 1'b1, 32'hBFC00204, 5'd5, 32'h88888888, 1'b0,
                     1'b0, 32'd0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};
        vecs[12] = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 32'hBFC00204, 5'd5, 32'h88888888, 1'b0,
                     1'b0, 32'd0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0};

        // Reset state
        do_reset();
        #1;
        check("reset pass_cnt", pass_cnt, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        check("reset err_pc", err_pc, 32'd0);
        check("reset err_wnum", 32'(err_wnum), 32'd0);
        check("reset err_wdata", err_wdata, 32'd0);
        check("reset gold_ready", 32'(gold_ready), 32'd0);

        // Vector table: clean stream, byte-masked match/mismatch, ignored commits
        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            else             @(negedge clk);
            set_commit(vecs[k].pc, vecs[k].wen, vecs[k].wnum, vecs[k].wdata);
            set_gold(vecs[k].gv, vecs[k].gpc, vecs[k].gwnum, vecs[k].gwdata, vecs[k].glast);
            #1;
            check($sformatf("v%0d gold_ready", k), 32'(gold_ready), 32'(vecs[k].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d pass_cnt", k), pass_cnt, vecs[k].exp_pass);
            check($sformatf("v%0d done", k), 32'(done), 32'(vecs[k].exp_done));
            check($sformatf("v%0d err_code", k), 32'(err_code), 32'(vecs[k].exp_code));
            check($sformatf("v%0d err", k), 32'(err), 32'(vecs[k].exp_code != 2'd0));
            check($sformatf("v%0d err_pc", k), err_pc, vecs[k].exp_err_pc);
            check($sformatf("v%0d err_wnum", k), 32'(err_wnum), 32'(vecs[k].exp_err_wnum));
            check($sformatf("v%0d err_wdata", k), err_wdata, vecs[k].exp_err_wdata);
        end

        // Overflow: 8 commits fill the FIFO, the 9th with no pop is an error
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            set_commit(e_pc(i), 4'hF, e_wnum(i), e_wdata(i));
            @(posedge clk);
            #1;
            if (i == 7) check("ovf full no error", 32'(err_code), 32'd0);
        end
        check("ovf err_code", 32'(err_code), 32'd2);
        check("ovf err", 32'(err), 32'd1);
        check("ovf gold_ready", 32'(gold_ready), 32'd0);

        // Full FIFO with a simultaneous pop: legal, then drain to DONE
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            set_commit(e_pc(i), 4'hF, e_wnum(i), e_wdata(i));
            if (i == 8) set_gold(1'b1, e_pc(0), e_wnum(0), e_wdata(0), 1'b0);
            @(posedge clk);
            #1;
        end
        check("full push+pop err_code", 32'(err_code), 32'd0);
        check("full push+pop pass_cnt", pass_cnt, 32'd1);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            set_commit(32'h0, 4'h0, 5'd0, 32'h0);
            set_gold(1'b1, e_pc(i), e_wnum(i), e_wdata(i), i == 8);
            @(posedge clk);
            #1;
        end
        check("drain pass_cnt", pass_cnt, 32'd9);
        check("drain done", 32'(done), 32'd1);
        check("drain err_code", 32'(err_code), 32'd0);

        // Timeout: no commits after reset release
        do_reset();
        for (int c = 0; c < 15; c++) @(posedge clk);
        #1;
        check("timeout not yet", 32'(err_code), 32'd0);
        @(posedge clk);
        #1;
        check("timeout err_code", 32'(err_code), 32'd3);
        check("timeout err", 32'(err), 32'd1);

        // A commit every 10 cycles never times out
        do_reset();
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 10 == 0) set_commit(32'h3000 + 32'(c), 4'hF, 5'd7, 32'(c));
            else             set_commit(32'h0, 4'h0, 5'd0, 32'h0);
            @(posedge clk);
        end
        #1;
        check("periodic err_code", 32'(err_code), 32'd0);
        check("periodic err", 32'(err), 32'd0);

        // Reset mid-run
        do_reset();
        set_commit(32'h2000, 4'hF, 5'd1, 32'hDEAD0001);
        @(posedge clk);
        @(negedge clk);
        set_commit(32'h2004, 4'hF, 5'd2, 32'hDEAD0002);
        set_gold(1'b1, 32'h2000, 5'd1, 32'hDEAD0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_commit(32'h2008, 4'hF, 5'd3, 32'hDEAD0003);
        set_gold(1'b1, 32'h2004, 5'd2, 32'hDEAD0002, 1'b0);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        check("midrun pass_cnt", pass_cnt, 32'd2);
        check("midrun gold_ready", 32'(gold_ready), 32'd1);
        resetn = 1'b0;
        #1;
        check("async rst pass_cnt", pass_cnt, 32'd0);
        check("async rst err", 32'(err), 32'd0);
        check("async rst gold_ready", 32'(gold_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        set_commit(32'h2100, 4'hF, 5'd9, 32'hCAFE0009);
        @(posedge clk);
        @(negedge clk);
        set_commit(32'h0, 4'h0, 5'd0, 32'h0);
        set_gold(1'b1, 32'h2100, 5'd9, 32'hCAFE0009, 1'b1);
        #1;
        check("post rst gold_ready", 32'(gold_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post rst pass_cnt", pass_cnt, 32'd1);
        check("post rst done", 32'(done), 32'd1);
        check("post rst err_code", 32'(err_code), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
